// File: rtl/tdm4_demux_rx_if.sv
// tdm4_demux_rx_if
// Bundles the TDM receive bus and the recovered-frame outputs of tdm4_demux_rx.
//   din, din_valid, sync          : shared TDM stream, driven by the source (master)
//   Y0..Y3                        : last complete frame, channels 0..3
//   frame_valid                   : one-cycle pulse when Y0..Y3 update
//   locked, slot                  : lock state and next expected slot index
//   sync_err                      : one-cycle pulse on a framing violation
// The demux itself connects through the slave modport.
interface tdm4_demux_rx_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Y2;
  logic [WIDTH-1:0] Y3;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;

  modport master (
    output din, din_valid, sync,
    input  Y0, Y1, Y2, Y3, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output Y0, Y1, Y2, Y3, frame_valid, locked, slot, sync_err
  );
endinterface

// File: rtl/tdm4_demux_rx.sv
// tdm4_demux_rx
// Recovers four parallel channels from a 4-slot TDM stream. Slot 0 is marked
// by sync. A two-state lock FSM plus a 2-bit slot counter track the position;
// slots 0..2 are held in shadow registers and all four outputs are loaded
// together on the slot-3 beat, so a partially received frame is never visible.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : tdm4_demux_rx_if.slave (din/din_valid/sync in; Y0..Y3,
//          frame_valid, locked, slot, sync_err out, all registered)
module tdm4_demux_rx #(
  parameter int WIDTH = 3
) (
  input logic            clk,
  input logic            rst,
  tdm4_demux_rx_if.slave bus
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_reg;
  logic [1:0]       slot_reg;
  logic [WIDTH-1:0] s_reg [0:2];
  logic [WIDTH-1:0] y_reg [0:3];
  logic             frame_valid_reg;
  logic             sync_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      slot_reg        <= 2'd0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) s_reg[i] <= '0;
      for (int i = 0; i < 4; i++) y_reg[i] <= '0;
    end else begin
      // Pulses last one cycle; they are re-asserted only by a triggering beat.
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      if (bus.din_valid) begin
        case (state_reg)
          HUNT: begin
            // Non-sync beats are simply ignored while hunting.
            if (bus.sync) begin
              s_reg[0]  <= bus.din;
              slot_reg  <= 2'd1;
              state_reg <= LOCK;
            end
          end
          LOCK: begin
            if (bus.sync) begin
              // Sync at slot 0 is the expected start; anywhere else it is an
              // early sync that drops the partial frame and restarts at slot 0.
              if (slot_reg != 2'd0) sync_err_reg <= 1'b1;
              s_reg[0] <= bus.din;
              slot_reg <= 2'd1;
            end else if (slot_reg == 2'd0) begin
              // Missing sync where one was due: lose lock and discard the beat.
              sync_err_reg <= 1'b1;
              slot_reg     <= 2'd0;
              state_reg    <= HUNT;
            end else if (slot_reg == 2'd3) begin
              y_reg[0]        <= s_reg[0];
              y_reg[1]        <= s_reg[1];
              y_reg[2]        <= s_reg[2];
              y_reg[3]        <= bus.din;
              frame_valid_reg <= 1'b1;
              slot_reg        <= 2'd0;
            end else begin
              if (slot_reg == 2'd1) s_reg[1] <= bus.din;
              else                  s_reg[2] <= bus.din;
              slot_reg <= slot_reg + 2'd1;
            end
          end
          default: begin
            state_reg <= HUNT;
            slot_reg  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.Y0          = y_reg[0];
  assign bus.Y1          = y_reg[1];
  assign bus.Y2          = y_reg[2];
  assign bus.Y3          = y_reg[3];
  assign bus.frame_valid = frame_valid_reg;
  assign bus.sync_err    = sync_err_reg;
  assign bus.locked      = (state_reg == LOCK);
  assign bus.slot        = slot_reg;

endmodule
